pwm_ramp_ctrl: RTL and testbench
================================

// Module: pwm_ramp_ctrl
// PURPOSE
//   Sequencer for one pwm channel: accepts duty targets over valid/ready, steps
//   the pwm threshold toward target by a programmable amount once per pwm period.
//   Updates land only on period wrap, so no glitch or partial period is produced.
//   Keeps a period counter in lock-step with the pwm counter; sits between the
//   register bank and the pwm instance, whose threshold port it drives.
// PARAMETERS
//   NBITS  10  threshold/counter width; period = 2**NBITS clk cycles
// PORTS
//   clk           in   1      clock, all logic on rising edge
//   resetn        in   1      asynchronous, active-low reset
//   enable        in   1      1 = run; 0 = abort, threshold 0, counter held at 0
//   s_valid       in   1      target request valid
//   s_ready       out  1      controller accepts a target this cycle
//   s_target      in   NBITS  requested duty (threshold value)
//   step          in   NBITS  per-period increment; 0 = jump to target
//   threshold     out  NBITS  drives pwm threshold
//   period_start  out  1      1 while cnt==0 (first cycle of each period)
//   busy          out  1      1 while state RAMP
//   done          out  1      one-cycle pulse when threshold reaches target
// BEHAVIOUR
//   Reset: state IDLE, cnt=0, threshold=0, target=0; s_ready=0, busy=0, done=0.
//   cnt: NBITS-bit, +1 per clk while enable=1, natural wrap 2**NBITS-1 -> 0.
//     "wrap edge" = clk edge at which cnt==2**NBITS-1 (and enable=1).
//   States IDLE, RAMP. All outputs registered, except s_ready (=enable & IDLE).
//   IDLE: s_valid&s_ready latches target (clamped, see CONFIGURATION) -> RAMP.
//     Acceptance on the wrap edge itself does not update threshold on that edge;
//     first update is the next wrap edge (latency 1..2**NBITS cycles).
//   RAMP: s_ready=0, s_target/step ignored except step sampled at each wrap edge.
//     At wrap edge, d=|target-threshold|:
//       step==0 or d<=step -> threshold<=target, done pulse, -> IDLE.
//       else threshold<=threshold±step (toward target), stay RAMP.
//     No over/underflow: arithmetic in NBITS+1 bits; result never passes target.
//     target==threshold at acceptance -> done on next wrap edge, threshold unchanged.
//   enable 1->0 at any time (incl. mid-ramp): next edge cnt=0, threshold=0,
//     state IDLE, pending target dropped, no done. Resumes counting from 0 when
//     enable returns; pwm instance must be reset off ~enable to stay aligned.
//   done and a new acceptance cannot coincide (s_ready=0 in RAMP); earliest new
//     acceptance is the cycle after done.
//   resetn asserted mid-ramp: immediate return to reset values.
// CONFIGURATION
//   PWM_RAMP_CTRL_CLAMP_EN defined: extra input max_duty [NBITS]; target latched
//     as min(s_target, max_duty); max_duty sampled only at acceptance.
//   Not defined: no max_duty port; target = s_target unmodified.
// TESTING (NBITS=4, period 16)
//   reset, enable=1, no requests -> threshold=0, period_start every 16 cycles, done=0.
//   s_target=12, step=4 from 0 -> threshold 4,8,12 on 3 successive wrap edges;
//     done once with 12; s_ready=1 the cycle after done.
//   s_target=3, step=0 from 12 -> threshold 3 at next wrap edge, single done.
//   s_target=15, step=6 from 3 -> 9, then 15 (d=6<=6), no overshoot, no wrap to 0.
//   accept on the wrap edge cycle -> threshold unchanged until the following wrap.
//   enable=0 mid-ramp (threshold=8, target=12) -> threshold=0, cnt=0, IDLE, no done.
//   CLAMP_EN: max_duty=10, s_target=14, step=0 -> threshold 10, done.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: duty-target sequencer for one pwm channel.
// Accepts a target over valid/ready and steps the threshold toward it once per
// pwm period, always on the period wrap so the pwm never sees a partial period.
// Ports:
//   clk, resetn (async, active-low), enable (0 = abort, hold counter at 0)
//   s_valid/s_ready/s_target : target request handshake
//   step         : per-period increment, 0 = jump straight to target
//   threshold    : pwm threshold drive
//   period_start : high while the period counter is 0
//   busy         : high while ramping
//   done         : one-cycle pulse when threshold reaches target
// Optional: define PWM_RAMP_CTRL_CLAMP_EN to add max_duty, which clamps the
// accepted target to min(s_target, max_duty).
module pwm_ramp_ctrl #(
    parameter int NBITS = 10
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [NBITS-1:0] s_target,
    input  logic [NBITS-1:0] step,
`ifdef PWM_RAMP_CTRL_CLAMP_EN
    input  logic [NBITS-1:0] max_duty,
`endif
    output logic [NBITS-1:0] threshold,
    output logic             period_start,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    localparam logic [NBITS-1:0] ONE = {{(NBITS-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [NBITS-1:0] cnt_q, cnt_d;
    logic [NBITS-1:0] thr_q, thr_d;
    logic [NBITS-1:0] tgt_q, tgt_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             pstart_q, pstart_d;

    logic [NBITS-1:0] acc_tgt;
    logic             wrap;
    logic             up;
    logic [NBITS:0]   diff;

`ifdef PWM_RAMP_CTRL_CLAMP_EN
    assign acc_tgt = (s_target > max_duty) ? max_duty : s_target;
`else
    assign acc_tgt = s_target;
`endif

    assign wrap    = enable && (cnt_q == '1);
    assign up      = (tgt_q >= thr_q);
    assign diff    = up ? ({1'b0, tgt_q} - {1'b0, thr_q})
                        : ({1'b0, thr_q} - {1'b0, tgt_q});
    assign s_ready = enable && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        thr_d   = thr_q;
        tgt_d   = tgt_q;
        done_d  = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            thr_d   = '0;
            tgt_d   = '0;
        end else begin
            cnt_d = cnt_q + ONE;
            unique case (state_q)
                IDLE: begin
                    // Acceptance never moves threshold, even on a wrap edge.
                    if (s_valid) begin
                        tgt_d   = acc_tgt;
                        state_d = RAMP;
                    end
                end
                RAMP: begin
                    if (wrap) begin
                        if ((step == '0) || ({1'b0, step} >= diff)) begin
                            thr_d   = tgt_q;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else if (up) begin
                            // diff > step, so neither add nor subtract can
                            // wrap or pass the target.
                            thr_d = thr_q + step;
                        end else begin
                            thr_d = thr_q - step;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d   = (state_d == RAMP);
        pstart_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            thr_q    <= '0;
            tgt_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            pstart_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            thr_q    <= thr_d;
            tgt_q    <= tgt_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            pstart_q <= pstart_d;
        end
    end

    assign threshold    = thr_q;
    assign done         = done_q;
    assign busy         = busy_q;
    assign period_start = pstart_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: phase table, corner sequences and random stimulus
// against a behavioural model of the ramp controller (NBITS=4).
module tb_pwm_ramp_ctrl;

    localparam int NB = 4;
    localparam int P  = 16;

    logic          clk = 1'b0;
    logic          resetn;
    logic          enable;
    logic          s_valid;
    logic          s_ready;
    logic [NB-1:0] s_target;
    logic [NB-1:0] step;
    logic [NB-1:0] max_duty;
    logic [NB-1:0] threshold;
    logic          period_start;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(.NBITS(NB)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_target    (s_target),
        .step        (step),
`ifdef PWM_RAMP_CTRL_CLAMP_EN
        .max_duty    (max_duty),
`endif
        .threshold   (threshold),
        .period_start(period_start),
        .busy        (busy),
        .done        (done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen;

    // Model state: counter, threshold, target, ramping flag, done pulse.
    int m_cnt, m_thr, m_tgt;
    bit m_ramp, m_done;

    typedef struct {
        bit en;
        bit v;
        int tgt;
        int stp;
        int md;
        int n;
        int e_thr;
        int e_busy;
        int e_done;
    } ph_t;

    ph_t tbl[$];

    task automatic check(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_cnt  = 0;
        m_thr  = 0;
        m_tgt  = 0;
        m_ramp = 0;
        m_done = 0;
    endfunction

    function automatic void model_edge();
        int t, s, md, nxt;
        bit wrapped;
        if (!resetn) begin
            model_reset();
            return;
        end
        m_done = 0;
        if (!enable) begin
            model_reset();
            return;
        end
        wrapped = (m_cnt == P - 1);
        s = int'(step);
        if (!m_ramp) begin
            if (s_valid) begin
                t  = int'(s_target);
`ifdef PWM_RAMP_CTRL_CLAMP_EN
                md = int'(max_duty);
                if (t > md) t = md;
`else
                md = P - 1;
`endif
                m_tgt  = t;
                m_ramp = 1;
            end
        end else if (wrapped) begin
            if (s == 0) nxt = m_tgt;
            else if (m_tgt > m_thr) nxt = (m_thr + s < m_tgt) ? m_thr + s : m_tgt;
            else nxt = (m_thr - s > m_tgt) ? m_thr - s : m_tgt;
            m_thr = nxt;
            if (nxt == m_tgt) begin
                m_done = 1;
                m_ramp = 0;
            end
        end
        m_cnt = (m_cnt + 1) % P;
    endfunction

    task automatic compare_all();
        check("threshold", int'(threshold), m_thr);
        check("done", int'(done), int'(m_done));
        check("busy", int'(busy), int'(m_ramp));
        check("period_start", int'(period_start), int'(m_cnt == 0));
        check("s_ready", int'(s_ready), int'(enable && !m_ramp));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        if (done) done_seen++;
    endtask

    function automatic ph_t mk(bit en, bit v, int tgt, int stp, int md, int n,
                               int e_thr, int e_busy, int e_done);
        ph_t p;
        p.en = en; p.v = v; p.tgt = tgt; p.stp = stp; p.md = md; p.n = n;
        p.e_thr = e_thr; p.e_busy = e_busy; p.e_done = e_done;
        return p;
    endfunction

    initial begin
        resetn   = 1'b0;
        enable   = 1'b0;
        s_valid  = 1'b0;
        s_target = '0;
        step     = '0;
        max_duty = '1;
        model_reset();

        // Idle: no requests.
        tbl.push_back(mk(1, 0, 0, 0, 15, 32, 0, 0, 0));
        // 0 -> 12 by 4: three wraps.
        tbl.push_back(mk(1, 1, 12, 4, 15, 48, 12, 0, 1));
        // 12 -> 3 jump.
        tbl.push_back(mk(1, 1, 3, 0, 15, 16, 3, 0, 1));
        // 3 -> 15 by 6: 9 then 15, no overshoot.
        tbl.push_back(mk(1, 1, 15, 6, 15, 32, 15, 0, 1));
        // Park counter at 15, then accept on the wrap edge.
        tbl.push_back(mk(1, 0, 0, 0, 15, 15, 15, 0, 0));
        tbl.push_back(mk(1, 1, 7, 0, 15, 1, 15, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 15, 15, 15, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 15, 1, 7, 0, 1));
        // Back to 0, then ramp to 8 toward 12 and abort.
        tbl.push_back(mk(1, 1, 0, 0, 15, 16, 0, 0, 1));
        tbl.push_back(mk(1, 1, 12, 4, 15, 32, 8, 1, 0));
        tbl.push_back(mk(0, 0, 0, 4, 15, 3, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 4, 15, 32, 0, 0, 0));
`ifdef PWM_RAMP_CTRL_CLAMP_EN
        tbl.push_back(mk(1, 1, 14, 0, 10, 16, 10, 0, 1));
`endif

        tick();
        tick();
        @(negedge clk);
        resetn = 1'b1;
        enable = 1'b1;

        foreach (tbl[i]) begin
            enable    = tbl[i].en;
            s_valid   = tbl[i].v;
            s_target  = NB'(tbl[i].tgt);
            step      = NB'(tbl[i].stp);
            max_duty  = NB'(tbl[i].md);
            done_seen = 0;
            for (int c = 0; c < tbl[i].n; c++) begin
                tick();
                s_valid = 1'b0;
            end
            check($sformatf("phase%0d_thr", i), int'(threshold), tbl[i].e_thr);
            check($sformatf("phase%0d_busy", i), int'(busy), tbl[i].e_busy);
            check($sformatf("phase%0d_done", i), done_seen, tbl[i].e_done);
        end

        for (int c = 0; c < 3000; c++) begin
            enable   = ($urandom_range(0, 99) != 0);
            s_valid  = ($urandom_range(0, 3) == 0);
            s_target = NB'($urandom_range(0, P - 1));
            step     = NB'($urandom_range(0, 7));
            max_duty = NB'($urandom_range(0, P - 1));
            tick();
        end

        // Asynchronous reset in the middle of a ramp.
        enable = 1'b0;
        tick();
        enable   = 1'b1;
        s_valid  = 1'b1;
        s_target = NB'(12);
        step     = NB'(1);
        max_duty = '1;
        tick();
        s_valid = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        check("pre_reset_busy", int'(busy), 1);
        check("pre_reset_thr", int'(threshold), 1);
        resetn = 1'b0;
        #1;
        model_reset();
        check("async_thr", int'(threshold), 0);
        check("async_busy", int'(busy), 0);
        check("async_done", int'(done), 0);
        check("async_pstart", int'(period_start), 1);
        enable = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
